apb_slave_regfile: RTL and testbench
====================================

Name: apb_slave_regfile

Overview:
- APB responder (completer) at the far end of the AHB-to-APB bridge. Answers one PSELx line with a word-addressed 32-bit register file.
- Inserts a programmable number of wait states through PREADY.
- Flags illegal accesses through PSLVERR.
- Gives the bridge and its bench a realistic peripheral, in place of a pass-through APB monitor.

Parameters:
- BASE_ADDR, 32'h8000_0000, byte address of register 0; the decode window starts here.
- NUM_REGS, 16, number of 32-bit registers; must be a power of two, from 2 to 256.
- WAIT_STATES, 0, extra access-phase cycles before PREADY (0–15).
- ID_VALUE, 32'hA9B0_0001, constant returned by register 0, which is read-only.

Ports:
- HCLK  in  1  system clock; all logic on the rising edge.
- HRESETn  in  1  reset, synchronous, active-low.
- PSEL  in  1  select; one bit of the bridge's PSELx.
- PENABLE  in  1  access-phase strobe.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  32  byte address.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data; valid while PREADY=1 on a read.
- PREADY  out  1  transfer-complete strobe.
- PSLVERR  out  1  error response; valid only while PREADY=1.

Behaviour:
- Reset: when HRESETn=0 at a rising edge:
  - FSM goes to IDLE, the wait counter clears to 0, registers 1..NUM_REGS-1 clear to 0.
  - PRDATA=0, PREADY=0, PSLVERR=0 from the next cycle on.
  - Reset always overrides any transfer in progress; an in-flight write is dropped.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE -> SETUP when PSEL=1 and PENABLE=0.
  - SETUP -> ACCESS on the next edge. At the same edge: wait counter loads WAIT_STATES; PADDR and PWRITE are captured.
  - ACCESS with counter!=0: decrement the counter, stay in ACCESS.
  - ACCESS with counter==0: transfer completes at this edge. If PSEL=1 and PENABLE=0 (back-to-back setup), go to SETUP; otherwise go to IDLE.
  - PSEL=1 with PENABLE=1 while in IDLE (protocol violation): ignored, stay in IDLE, PREADY stays 0.
  - PSEL falls while in ACCESS: abort to IDLE, no write, no response.
- PREADY is combinational: state==ACCESS && counter==0 && PSEL && PENABLE. It is low in every other cycle.
- Latency: transfer completes in access cycle WAIT_STATES+1; total bus cycles per transfer = WAIT_STATES+2.
- Decode, using the captured address:
  - offset = PADDR - BASE_ADDR.
  - index = offset[log2(NUM_REGS)+1:2].
  - Error if offset[1:0]!=0 (misaligned), if offset >= NUM_REGS*4 (out of range), or if PWRITE=1 with index==0.
- Write: PWDATA is written into reg[index] at the edge where PREADY=1, only if there is no error. PWDATA is sampled at that edge, not at setup.
- Read: PRDATA is registered at the SETUP->ACCESS edge. It holds ID_VALUE for index 0, reg[index] otherwise, and 0 on error. It holds its value until the next SETUP.
- PSLVERR is combinational: PREADY && error.
- Read-after-write, back-to-back: the read sees the new value, because the write commits before the read's setup edge.

Decomposition:
- Package apb_pkg:
  - FSM state encoding: IDLE=2'b00, SETUP=2'b01, ACCESS=2'b10.
  - Transfer direction constants: APB_READ=1'b0, APB_WRITE=1'b1.
  - Default ID constant.
- One sub-module, apb_addr_decode: purely combinational, computes {index, error} from address, PWRITE, BASE_ADDR and NUM_REGS.
- The FSM, wait counter and register array stay in apb_slave_regfile.

Test Plan:
- WAIT_STATES=0: write 32'hDEAD_BEEF to 0x8000_000C, then read 0x8000_000C -> PREADY high in the 2nd bus cycle of each transfer, PRDATA=32'hDEAD_BEEF, PSLVERR=0.
- WAIT_STATES=3: read 0x8000_0000 -> PREADY low for 3 access cycles then high for 1, PRDATA=32'hA9B0_0001.
- Write to 0x8000_0040 (out of range) and to 0x8000_0006 (misaligned) -> PREADY=1 with PSLVERR=1, no register changes; a following read of 0x8000_0004 returns 0.
- Write 32'h1234 to 0x8000_0000 (ID register) -> PSLVERR=1; a read-back still returns 32'hA9B0_0001.
- Back-to-back write 0x8000_0008=32'h5555_AAAA then read 0x8000_0008 with no IDLE cycle between -> read returns 32'h5555_AAAA, 4 cycles total at WAIT_STATES=0.
- HRESETn=0 during the ACCESS phase of a write 32'hFFFF_FFFF to 0x8000_0010 (WAIT_STATES=2) -> PREADY, PSLVERR and PRDATA are 0 on the next cycle; a later read of 0x8000_0010 returns 0.

Source files
------------

// File: rtl/apb_pkg.sv
// apb_pkg: shared constants for the APB register-file responder
//   FSM state encoding, transfer direction values and the default ID word.
package apb_pkg;
   localparam logic [1:0] IDLE   = 2'b00;
   localparam logic [1:0] SETUP  = 2'b01;
   localparam logic [1:0] ACCESS = 2'b10;
   localparam logic APB_READ  = 1'b0;
   localparam logic APB_WRITE = 1'b1;
   localparam logic [31:0] DEFAULT_ID = 32'hA9B0_0001;
endpackage

// File: rtl/apb_addr_decode.sv
// apb_addr_decode: maps a byte address to a register index and flags illegal accesses
//   addr  : byte address of the transfer
//   write : transfer direction (APB_WRITE / APB_READ)
//   index : word index into the register file
//   error : misaligned, outside the window, or a write to the read-only ID register
module apb_addr_decode
   import apb_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
   parameter int          NUM_REGS  = 16
) (
   input  logic [31:0]                 addr,
   input  logic                        write,
   output logic [$clog2(NUM_REGS)-1:0] index,
   output logic                        error
);
   localparam int          AW   = $clog2(NUM_REGS);
   localparam logic [31:0] SPAN = 32'(NUM_REGS * 4);
   logic [31:0] offset;
   // addresses below the base wrap to huge offsets and land in the out-of-range check
   assign offset = addr - BASE_ADDR;
   assign index  = offset[AW+1:2];
   assign error  = (offset[1:0] != 2'b00) || (offset >= SPAN) ||
                   (write == APB_WRITE && index == '0);
endmodule

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB completer with a word-addressed 32-bit register file
//   HCLK, HRESETn          : clock, synchronous active-low reset
//   PSEL, PENABLE, PWRITE  : APB control from the bridge
//   PADDR, PWDATA          : byte address and write data
//   PRDATA                 : registered read data, valid while PREADY on a read
//   PREADY, PSLVERR        : completion strobe after WAIT_STATES extra cycles, error flag
module apb_slave_regfile
   import apb_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter int          NUM_REGS    = 16,
   parameter int          WAIT_STATES = 0,
   parameter logic [31:0] ID_VALUE    = DEFAULT_ID
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        PSEL,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [31:0] PADDR,
   input  logic [31:0] PWDATA,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        PSLVERR
);
   localparam int AW = $clog2(NUM_REGS);
   logic [1:0]    state_q, state;
   logic [3:0]    cnt;
   logic [31:0]   addr_q;
   logic          write_q;
   logic [31:0]   regs [NUM_REGS];
   logic [31:0]   dec_addr;
   logic          dec_write;
   logic [AW-1:0] idx;
   logic          err;
   // Only ACCESS is held in a register; a setup phase is recognised straight off
   // the bus so that the setup cycle itself is SETUP and back-to-back transfers
   // need no idle cycle between them.
   always_comb state = (state_q == ACCESS) ? ACCESS : (PSEL && !PENABLE) ? SETUP : IDLE;
   // Decode the live bus during setup and the captured transfer during access.
   assign dec_addr  = (state_q == ACCESS) ? addr_q  : PADDR;
   assign dec_write = (state_q == ACCESS) ? write_q : PWRITE;
   apb_addr_decode #(.BASE_ADDR(BASE_ADDR), .NUM_REGS(NUM_REGS)) u_dec (
      .addr  (dec_addr),
      .write (dec_write),
      .index (idx),
      .error (err)
   );
   assign PREADY  = (state == ACCESS) && (cnt == 4'd0) && PSEL && PENABLE;
   assign PSLVERR = PREADY && err;
   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         state_q <= IDLE;
         cnt     <= 4'd0;
         addr_q  <= '0;
         write_q <= APB_READ;
         PRDATA  <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (state == SETUP) begin
         state_q <= ACCESS;
         cnt     <= 4'(WAIT_STATES);
         addr_q  <= PADDR;
         write_q <= PWRITE;
         PRDATA  <= err ? '0 : (idx == '0) ? ID_VALUE : regs[idx];
      end else if (state == ACCESS) begin
         // a dropped PSEL aborts; a zero count ends the transfer either way
         if (!PSEL || cnt == 4'd0) state_q <= IDLE;
         else cnt <= cnt - 4'd1;
         if (PREADY && write_q == APB_WRITE && !err) regs[idx] <= PWDATA;
      end
   end
endmodule

// File: tb/tb_apb_slave_regfile.sv
module tb_apb_slave_regfile;
   localparam logic [31:0] BASE = 32'h8000_0000;
   localparam logic [31:0] ID   = 32'hA9B0_0001;
   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic [2:0]  psel;
   logic        penable, pwrite;
   logic [31:0] paddr, pwdata;
   logic [31:0] prdata [3];
   logic [2:0]  pready, pslverr;
   int          pass_cnt = 0;
   int          total = 0;
   int          cyc = 0;
   logic [31:0] mem [3][16];

   apb_slave_regfile #(.WAIT_STATES(0)) u0 (
      .HCLK(HCLK), .HRESETn(HRESETn), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));
   apb_slave_regfile #(.WAIT_STATES(3)) u1 (
      .HCLK(HCLK), .HRESETn(HRESETn), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));
   apb_slave_regfile #(.WAIT_STATES(2)) u2 (
      .HCLK(HCLK), .HRESETn(HRESETn), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

   always #5 HCLK = ~HCLK;
   always @(posedge HCLK) cyc <= cyc + 1;

   function automatic int ws_of(input int d);
      return d == 0 ? 0 : d == 1 ? 3 : 2;
   endfunction

   function automatic bit m_err(input bit w, input logic [31:0] a);
      logic [31:0] o;
      o = a - BASE;
      return (o % 4 != 0) || (o >= 64) || (w && o == 0);
   endfunction

   function automatic logic [31:0] m_read(input int d, input logic [31:0] a);
      logic [31:0] o;
      o = a - BASE;
      if (m_err(1'b0, a)) return 32'h0;
      if (o == 0) return ID;
      return mem[d][o / 4];
   endfunction

   task automatic m_write(input int d, input logic [31:0] a, input logic [31:0] v);
      logic [31:0] o;
      o = a - BASE;
      if (!m_err(1'b1, a)) mem[d][o / 4] = v;
   endtask

   task automatic m_clear();
      for (int d = 0; d < 3; d++) for (int i = 0; i < 16; i++) mem[d][i] = 32'h0;
   endtask

   // Drives one complete transfer; PWDATA carries garbage in setup and the real
   // value only in access, since it is sampled at completion. waits = -1 on timeout.
   task automatic xfer(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output bit er, output int waits);
      psel[d] = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = ~wd;
      @(posedge HCLK); #1;
      penable = 1'b1; pwdata = wd;
      waits = 0;
      forever begin
         @(negedge HCLK);
         if (pready[d]) break;
         waits++;
         if (waits > 40) begin waits = -1; break; end
      end
      rd = prdata[d]; er = pslverr[d];
      @(posedge HCLK); #1;
      psel[d] = 1'b0; penable = 1'b0;
   endtask

   task automatic test_reset();
      HRESETn = 1'b0; psel = 3'b000; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
      m_clear();
      repeat (2) @(posedge HCLK);
      #1 HRESETn = 1'b1;
      @(negedge HCLK);
      for (int d = 0; d < 3; d++) begin
         total++;
         if ({prdata[d], pready[d], pslverr[d]} !== 34'h0)
            $display("FAIL reset d%0d: prdata=%h pready=%b pslverr=%b, want all 0", d, prdata[d], pready[d], pslverr[d]);
         else pass_cnt++;
      end
      @(posedge HCLK); #1;
   endtask

   task automatic test_basic();
      logic [31:0] rd; bit er; int wt;
      xfer(0, 1'b1, 32'h8000_000C, 32'hDEAD_BEEF, rd, er, wt); m_write(0, 32'h8000_000C, 32'hDEAD_BEEF);
      total++;
      if (er !== 1'b0 || wt != 0) $display("FAIL basic_write: err=%b waits=%0d, want 0/0", er, wt);
      else pass_cnt++;
      xfer(0, 1'b0, 32'h8000_000C, 32'h0, rd, er, wt);
      total++;
      if (rd !== 32'hDEAD_BEEF || er !== 1'b0 || wt != 0)
         $display("FAIL basic_read: rd=%h err=%b waits=%0d, want deadbeef/0/0", rd, er, wt);
      else pass_cnt++;
   endtask

   task automatic test_wait_states();
      logic [31:0] rd; bit er; int wt;
      xfer(1, 1'b0, 32'h8000_0000, 32'h0, rd, er, wt);
      total++;
      if (rd !== ID || er !== 1'b0 || wt != 3)
         $display("FAIL wait_id_read: rd=%h err=%b waits=%0d, want %h/0/3", rd, er, wt, ID);
      else pass_cnt++;
   endtask

   task automatic test_errors();
      logic [31:0] rd; bit er; int wt;
      xfer(0, 1'b1, 32'h8000_0040, 32'h1111_2222, rd, er, wt);
      total++;
      if (er !== 1'b1 || wt != 0) $display("FAIL err_range: err=%b waits=%0d, want 1/0", er, wt);
      else pass_cnt++;
      xfer(0, 1'b1, 32'h8000_0006, 32'h3333_4444, rd, er, wt);
      total++;
      if (er !== 1'b1) $display("FAIL err_misaligned: err=%b, want 1", er);
      else pass_cnt++;
      xfer(0, 1'b0, 32'h8000_0004, 32'h0, rd, er, wt);
      total++;
      if (rd !== 32'h0 || er !== 1'b0) $display("FAIL err_readback4: rd=%h err=%b, want 0/0", rd, er);
      else pass_cnt++;
      xfer(0, 1'b0, 32'h8000_000C, 32'h0, rd, er, wt);
      total++;
      if (rd !== m_read(0, 32'h8000_000C)) $display("FAIL err_readback12: rd=%h, want %h", rd, m_read(0, 32'h8000_000C));
      else pass_cnt++;
      xfer(0, 1'b0, 32'h8000_0041, 32'h0, rd, er, wt);
      total++;
      if (rd !== 32'h0 || er !== 1'b1) $display("FAIL err_read_bad: rd=%h err=%b, want 0/1", rd, er);
      else pass_cnt++;
   endtask

   task automatic test_id_write();
      logic [31:0] rd; bit er; int wt;
      xfer(0, 1'b1, 32'h8000_0000, 32'h0000_1234, rd, er, wt);
      total++;
      if (er !== 1'b1) $display("FAIL id_write: err=%b, want 1", er);
      else pass_cnt++;
      xfer(0, 1'b0, 32'h8000_0000, 32'h0, rd, er, wt);
      total++;
      if (rd !== ID || er !== 1'b0) $display("FAIL id_readback: rd=%h err=%b, want %h/0", rd, er, ID);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd; bit er; int wt; int c0;
      c0 = cyc;
      xfer(0, 1'b1, 32'h8000_0008, 32'h5555_AAAA, rd, er, wt); m_write(0, 32'h8000_0008, 32'h5555_AAAA);
      xfer(0, 1'b0, 32'h8000_0008, 32'h0, rd, er, wt);
      total++;
      if (rd !== 32'h5555_AAAA || er !== 1'b0) $display("FAIL b2b_read: rd=%h err=%b, want 5555aaaa/0", rd, er);
      else pass_cnt++;
      total++;
      if (cyc - c0 != 4) $display("FAIL b2b_cycles: got %0d cycles, want 4", cyc - c0);
      else pass_cnt++;
   endtask

   task automatic test_random();
      logic [31:0] rd, a, wd, o; bit er, w; int wt;
      for (int n = 0; n < 150; n++) begin
         int d;
         d = n % 3;
         o = $urandom_range(0, 75);
         if ($urandom_range(0, 3) != 0) o = o & ~32'h3;
         a = BASE + o;
         w = 1'($urandom_range(0, 1));
         wd = $urandom;
         xfer(d, w, a, wd, rd, er, wt);
         total++;
         if (er !== m_err(w, a) || wt != ws_of(d))
            $display("FAIL rand_resp d%0d a=%h w=%b: err=%b waits=%0d, want %b/%0d", d, a, w, er, wt, m_err(w, a), ws_of(d));
         else pass_cnt++;
         if (w) m_write(d, a, wd);
         else begin
            total++;
            if (rd !== m_read(d, a)) $display("FAIL rand_read d%0d a=%h: rd=%h, want %h", d, a, rd, m_read(d, a));
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_reset_midwrite();
      logic [31:0] rd; bit er; int wt;
      xfer(2, 1'b1, 32'h8000_0010, 32'h0BAD_F00D, rd, er, wt);
      psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8000_0010; pwdata = 32'hFFFF_FFFF;
      @(posedge HCLK); #1;
      penable = 1'b1;
      @(negedge HCLK);
      total++;
      if (pready[2] !== 1'b0 || prdata[2] !== 32'h0BAD_F00D)
         $display("FAIL midwrite_access: pready=%b prdata=%h, want 0/0badf00d", pready[2], prdata[2]);
      else pass_cnt++;
      HRESETn = 1'b0;
      @(posedge HCLK); #1;
      HRESETn = 1'b1; psel = 3'b000; penable = 1'b0;
      m_clear();
      @(negedge HCLK);
      total++;
      if ({prdata[2], pready[2], pslverr[2]} !== 34'h0)
         $display("FAIL midwrite_reset: prdata=%h pready=%b pslverr=%b, want all 0", prdata[2], pready[2], pslverr[2]);
      else pass_cnt++;
      @(posedge HCLK); #1;
      xfer(2, 1'b0, 32'h8000_0010, 32'h0, rd, er, wt);
      total++;
      if (rd !== 32'h0 || er !== 1'b0 || wt != 2)
         $display("FAIL midwrite_readback: rd=%h err=%b waits=%0d, want 0/0/2", rd, er, wt);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wait_states();
      test_errors();
      test_id_write();
      test_back_to_back();
      test_random();
      test_reset_midwrite();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
